// File: rtl/riscv_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_csr_pkg
// Description : Shared definitions for the machine-mode CSR / trap unit:
//               CSR addresses, interrupt cause codes, CSR bit positions,
//               CSR instruction op encodings and the trap FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Interrupt cause codes (mcause[4:0])
    localparam logic [4:0] CAUSE_TIMER = 5'd7;
    localparam logic [4:0] CAUSE_EXT   = 5'd11;

    // Bit positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIE_MEIE_BIT     = 11;
    localparam int MIP_MTIP_BIT     = 7;
    localparam int MIP_MEIP_BIT     = 11;

    // CSR instruction funct3 encodings
    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_e;

    // Trap FSM
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } trap_state_e;

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit free/conditionally running counter with independent
//               write ports for the low and high 32-bit halves. A write to a
//               half replaces that half's increment; the carry out of the low
//               half still reaches the high half unless the high half is
//               itself being written. Wraps silently.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               inc_en      - add one this cycle
//               wr_lo/wr_hi - load wdata into the low/high half
//               wdata       - write data
//               count       - current 64-bit value
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic        w_carry;

    // Carry is taken from the pre-write low half so that a low-half write in
    // the same cycle does not suppress the pending rollover.
    assign w_carry = inc_en & (r_lo == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo <= 32'h0;
            r_hi <= 32'h0;
        end else begin
            if (wr_lo) begin
                r_lo <= wdata;
            end else if (inc_en) begin
                r_lo <= r_lo + 32'd1;
            end

            if (wr_hi) begin
                r_hi <= wdata;
            end else if (w_carry) begin
                r_hi <= r_hi + 32'd1;
            end
        end
    end

    assign count = {r_hi, r_lo};

endmodule
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_unit
// Description : Machine-mode CSR file and interrupt/trap controller for the
//               MW stage of the 3-stage RV32I pipeline. Executes CSR reads and
//               writes, takes timer/external interrupts, handles mret and
//               drives the PC redirect back to Fetch. Holds mcycle/minstret.
// Ports       : clk, rst                   - clock, sync active-high reset
//               valid_MW, Stall_MW         - MW occupancy / freeze
//               br_taken_MW                - MW instruction redirects PC
//               csr_reg_rdMW/csr_reg_wrMW  - CSR read / write enables
//               is_mretMW                  - MW instruction is mret
//               InstF_MW_funct3            - CSR op
//               csr_addr_MW                - CSR address
//               rs1_data_MW, zimm_MW       - register / immediate operand
//               pc_F                       - PC in Fetch (saved into mepc)
//               irq_timer, irq_ext         - level interrupt lines
//               csr_rdata                  - old CSR value to writeback
//               epc_taken, epc_pc          - redirect strobe and target
//               in_handler                 - trap handler active
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_unit
    import riscv_csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_MW,
    input  logic        Stall_MW,
    input  logic        br_taken_MW,
    input  logic        csr_reg_rdMW,
    input  logic        csr_reg_wrMW,
    input  logic        is_mretMW,
    input  logic [2:0]  InstF_MW_funct3,
    input  logic [11:0] csr_addr_MW,
    input  logic [31:0] rs1_data_MW,
    input  logic [4:0]  zimm_MW,
    input  logic [31:0] pc_F,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] epc_pc,
    output logic        in_handler
);

    // Architectural state
    logic        r_mie;
    logic        r_mpie;
    logic        r_mtie;
    logic        r_meie;
    logic [29:0] r_mtvec_base;
    logic        r_mtvec_mode;
    logic [29:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_mtip;
    logic        r_meip;
    trap_state_e r_state;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;

    logic [31:0] w_csr_val;
    logic [31:0] w_src;
    logic [31:0] w_new;
    logic        w_op_ok;
    logic        w_wr;
    logic        w_pend;
    logic        w_trap;
    logic        w_mret;
    logic [4:0]  w_cause;
    logic [31:0] w_vec_pc;
    logic        w_retire;
    logic        w_unused;

    // Current value of the addressed CSR
    always_comb begin
        w_csr_val = 32'h0;
        case (csr_addr_MW)
            CSR_MSTATUS: begin
                w_csr_val[MSTATUS_MIE_BIT]  = r_mie;
                w_csr_val[MSTATUS_MPIE_BIT] = r_mpie;
            end
            CSR_MIE: begin
                w_csr_val[MIE_MTIE_BIT] = r_mtie;
                w_csr_val[MIE_MEIE_BIT] = r_meie;
            end
            CSR_MTVEC:     w_csr_val = {r_mtvec_base, 1'b0, r_mtvec_mode};
            CSR_MEPC:      w_csr_val = {r_mepc, 2'b00};
            CSR_MCAUSE:    w_csr_val = r_mcause;
            CSR_MIP: begin
                w_csr_val[MIP_MTIP_BIT] = r_mtip;
                w_csr_val[MIP_MEIP_BIT] = r_meip;
            end
            CSR_MCYCLE:    w_csr_val = w_mcycle[31:0];
            CSR_MCYCLEH:   w_csr_val = w_mcycle[63:32];
            CSR_MINSTRET:  w_csr_val = w_minstret[31:0];
            CSR_MINSTRETH: w_csr_val = w_minstret[63:32];
            default:       w_csr_val = 32'h0;
        endcase
    end

    assign csr_rdata = csr_reg_rdMW ? w_csr_val : 32'h0;

    // Write data
    assign w_src = InstF_MW_funct3[2] ? {27'b0, zimm_MW} : rs1_data_MW;

    always_comb begin
        w_new   = w_csr_val;
        w_op_ok = 1'b1;
        case (InstF_MW_funct3)
            CSRRW,  CSRRWI: w_new = w_src;
            CSRRS,  CSRRSI: w_new = w_csr_val | w_src;
            CSRRC,  CSRRCI: w_new = w_csr_val & ~w_src;
            default:        w_op_ok = 1'b0;
        endcase
    end

    assign w_wr     = csr_reg_wrMW & valid_MW & ~Stall_MW & w_op_ok;
    assign w_retire = valid_MW & ~Stall_MW;

    // Interrupt / trap decision
    assign w_pend  = r_mie & ((r_meie & r_meip) | (r_mtie & r_mtip));
    assign w_trap  = w_pend & valid_MW & ~Stall_MW & ~br_taken_MW & ~is_mretMW;
    assign w_mret  = is_mretMW & valid_MW & ~Stall_MW;
    assign w_cause = (r_meie & r_meip) ? CAUSE_EXT : CAUSE_TIMER;

    assign w_vec_pc = {r_mtvec_base, 2'b00}
                    + (r_mtvec_mode ? {25'b0, w_cause, 2'b00} : 32'h0);

    assign epc_taken = w_trap | w_mret;

    // When idle the target simply shows the trap base (as mtvec reads).
    always_comb begin
        if (w_mret) begin
            epc_pc = {r_mepc, 2'b00};
        end else if (w_trap) begin
            epc_pc = w_vec_pc;
        end else begin
            epc_pc = {r_mtvec_base, 1'b0, r_mtvec_mode};
        end
    end

    assign in_handler = (r_state == HANDLER);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie        <= 1'b0;
            r_mpie       <= 1'b0;
            r_mtie       <= 1'b0;
            r_meie       <= 1'b0;
            r_mtvec_base <= RESET_MTVEC[31:2];
            r_mtvec_mode <= RESET_MTVEC[0];
            r_mepc       <= 30'h0;
            r_mcause     <= 32'h0;
            r_mtip       <= 1'b0;
            r_meip       <= 1'b0;
            r_state      <= RUN;
        end else begin
            r_mtip <= irq_timer;
            r_meip <= irq_ext;

            // CSR write first; trap/mret below override the fields they own.
            if (w_wr) begin
                case (csr_addr_MW)
                    CSR_MSTATUS: begin
                        r_mie  <= w_new[MSTATUS_MIE_BIT];
                        r_mpie <= w_new[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE: begin
                        r_mtie <= w_new[MIE_MTIE_BIT];
                        r_meie <= w_new[MIE_MEIE_BIT];
                    end
                    CSR_MTVEC: begin
                        r_mtvec_base <= w_new[31:2];
                        r_mtvec_mode <= w_new[0];
                    end
                    CSR_MEPC:   r_mepc   <= w_new[31:2];
                    CSR_MCAUSE: r_mcause <= w_new;
                    default: ;
                endcase
            end

            if (w_trap) begin
                r_mepc   <= pc_F[31:2];
                r_mcause <= {1'b1, 26'b0, w_cause};
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
                r_state  <= HANDLER;
            end else if (w_mret) begin
                r_mie    <= r_mpie;
                r_mpie   <= 1'b1;
                r_state  <= RUN;
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst    (rst),
        .inc_en (1'b1),
        .wr_lo  (w_wr & (csr_addr_MW == CSR_MCYCLE)),
        .wr_hi  (w_wr & (csr_addr_MW == CSR_MCYCLEH)),
        .wdata  (w_new),
        .count  (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst    (rst),
        .inc_en (w_retire),
        .wr_lo  (w_wr & (csr_addr_MW == CSR_MINSTRET)),
        .wr_hi  (w_wr & (csr_addr_MW == CSR_MINSTRETH)),
        .wdata  (w_new),
        .count  (w_minstret)
    );

    // Bits with no storage behind them (unimplemented CSR fields, PC alignment)
    assign w_unused = ^{w_new, pc_F[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_trap_unit
// Description : Directed self-checking bench for csr_trap_unit. Inputs are
//               driven 1 ns after the rising edge, outputs checked 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_trap_unit;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    localparam logic [2:0] F_RW  = 3'b001;
    localparam logic [2:0] F_RC  = 3'b011;
    localparam logic [2:0] F_RSI = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_MW, Stall_MW, br_taken_MW;
    logic        csr_reg_rdMW, csr_reg_wrMW, is_mretMW;
    logic [2:0]  InstF_MW_funct3;
    logic [11:0] csr_addr_MW;
    logic [31:0] rs1_data_MW;
    logic [4:0]  zimm_MW;
    logic [31:0] pc_F;
    logic        irq_timer, irq_ext;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc_pc;
    logic        in_handler;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_trap_unit #(.RESET_MTVEC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_MW        (valid_MW),
        .Stall_MW        (Stall_MW),
        .br_taken_MW     (br_taken_MW),
        .csr_reg_rdMW    (csr_reg_rdMW),
        .csr_reg_wrMW    (csr_reg_wrMW),
        .is_mretMW       (is_mretMW),
        .InstF_MW_funct3 (InstF_MW_funct3),
        .csr_addr_MW     (csr_addr_MW),
        .rs1_data_MW     (rs1_data_MW),
        .zimm_MW         (zimm_MW),
        .pc_F            (pc_F),
        .irq_timer       (irq_timer),
        .irq_ext         (irq_ext),
        .csr_rdata       (csr_rdata),
        .epc_taken       (epc_taken),
        .epc_pc          (epc_pc),
        .in_handler      (in_handler)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_MW = 0; Stall_MW = 0; br_taken_MW = 0;
        csr_reg_rdMW = 0; csr_reg_wrMW = 0; is_mretMW = 0;
        InstF_MW_funct3 = 3'b000; csr_addr_MW = 12'h0;
        rs1_data_MW = 32'h0; zimm_MW = 5'h0;
    endtask

    // CSR read-modify-write instruction; checks the old value returned.
    task automatic csr_op(input string tag, input logic [11:0] addr, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [4:0] zimm,
                          input logic [31:0] exp_old);
        idle();
        valid_MW = 1; csr_reg_rdMW = 1; csr_reg_wrMW = 1;
        csr_addr_MW = addr; InstF_MW_funct3 = f3; rs1_data_MW = rs1; zimm_MW = zimm;
        #1;
        check(tag, csr_rdata, exp_old);
        tick();
        idle();
    endtask

    // Non-retiring peek at a CSR (no clock edge).
    task automatic csr_peek(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        idle();
        csr_reg_rdMW = 1; csr_addr_MW = addr;
        #1;
        check(tag, csr_rdata, exp);
        idle();
    endtask

    initial begin
        idle();
        rst = 1; pc_F = 32'h0; irq_timer = 0; irq_ext = 0;
        tick(); tick();
        rst = 0;
        #1;
        // Reset state
        check("rst_epc_taken", {31'b0, epc_taken}, 32'h0);
        check("rst_epc_pc", epc_pc, 32'h0);
        check("rst_in_handler", {31'b0, in_handler}, 32'h0);
        check("rst_rdata", csr_rdata, 32'h0);
        csr_peek("rst_mtvec", A_MTVEC, 32'h0);

        // CSRRW mtvec, bit 1 not stored
        csr_op("rw_mtvec_old", A_MTVEC, F_RW, 32'h0000_1003, 5'd0, 32'h0);
        csr_peek("mtvec_bit1", A_MTVEC, 32'h0000_1001);
        csr_op("rw_mtvec_old2", A_MTVEC, F_RW, 32'h0000_1001, 5'd0, 32'h0000_1001);
        csr_peek("mtvec_rw", A_MTVEC, 32'h0000_1001);

        // Vectored timer trap
        csr_op("rsi_mstatus", A_MSTATUS, F_RSI, 32'h0, 5'd8, 32'h0);
        csr_peek("mstatus_mie", A_MSTATUS, 32'h0000_0008);
        csr_op("rw_mie", A_MIE, F_RW, 32'h0000_0080, 5'd0, 32'h0);
        csr_peek("mie_val", A_MIE, 32'h0000_0080);
        pc_F = 32'h40;
        irq_timer = 1;
        valid_MW = 1;
        #1;
        check("irq_not_yet", {31'b0, epc_taken}, 32'h0);
        tick();
        check("tmr_epc_taken", {31'b0, epc_taken}, 32'h1);
        check("tmr_epc_pc", epc_pc, 32'h0000_101C);
        tick();
        idle();
        irq_timer = 0;
        csr_peek("tmr_mepc", A_MEPC, 32'h40);
        csr_peek("tmr_mcause", A_MCAUSE, 32'h8000_0007);
        csr_peek("tmr_mstatus", A_MSTATUS, 32'h0000_0080);
        csr_peek("tmr_mip", A_MIP, 32'h0000_0080);
        check("tmr_in_handler", {31'b0, in_handler}, 32'h1);

        // mret from handler
        valid_MW = 1; is_mretMW = 1;
        #1;
        check("mret_taken", {31'b0, epc_taken}, 32'h1);
        check("mret_pc", epc_pc, 32'h40);
        tick();
        idle();
        csr_peek("mret_mstatus", A_MSTATUS, 32'h0000_0088);
        check("mret_in_handler", {31'b0, in_handler}, 32'h0);
        csr_peek("mip_clear", A_MIP, 32'h0);

        // Priority: external over timer, direct mode
        csr_op("rw_mtvec_200", A_MTVEC, F_RW, 32'h0000_0200, 5'd0, 32'h0000_1001);
        csr_op("rw_mie_880", A_MIE, F_RW, 32'h0000_0880, 5'd0, 32'h0000_0080);
        pc_F = 32'h124;
        irq_timer = 1; irq_ext = 1;
        tick();
        valid_MW = 1;
        #1;
        check("prio_taken", {31'b0, epc_taken}, 32'h1);
        check("prio_pc", epc_pc, 32'h0000_0200);
        tick();
        idle();
        irq_timer = 0; irq_ext = 0;
        csr_peek("prio_mcause", A_MCAUSE, 32'h8000_000B);
        csr_peek("prio_mepc", A_MEPC, 32'h124);
        valid_MW = 1; is_mretMW = 1;
        #1;
        check("prio_mret_pc", epc_pc, 32'h124);
        tick();
        idle();

        // Blocking by stall, then by branch
        irq_ext = 1;
        tick();
        pc_F = 32'h300;
        valid_MW = 1; Stall_MW = 1;
        #1;
        check("stall_blocks", {31'b0, epc_taken}, 32'h0);
        tick();
        check("stall_no_handler", {31'b0, in_handler}, 32'h0);
        Stall_MW = 0; br_taken_MW = 1;
        csr_reg_rdMW = 1; csr_addr_MW = A_MEPC;
        #1;
        check("br_blocks", {31'b0, epc_taken}, 32'h0);
        check("stall_mepc_kept", csr_rdata, 32'h124);
        tick();
        idle();
        valid_MW = 1;
        #1;
        check("unblocked_taken", {31'b0, epc_taken}, 32'h1);
        check("unblocked_pc", epc_pc, 32'h200);
        tick();
        idle();
        irq_ext = 0;
        csr_peek("unblocked_mepc", A_MEPC, 32'h300);
        valid_MW = 1; is_mretMW = 1;
        tick();
        idle();

        // mret while already in RUN stays in RUN
        valid_MW = 1; is_mretMW = 1;
        #1;
        check("run_mret_taken", {31'b0, epc_taken}, 32'h1);
        tick();
        idle();
        check("run_mret_state", {31'b0, in_handler}, 32'h0);

        // RC, unimplemented address, read-only mip
        csr_op("rc_mie", A_MIE, F_RC, 32'h0000_0800, 5'd0, 32'h0000_0880);
        csr_peek("rc_mie_val", A_MIE, 32'h0000_0080);
        csr_op("rw_unimpl", A_MSCRATCH, F_RW, 32'h1234, 5'd0, 32'h0);
        csr_peek("unimpl_read", A_MSCRATCH, 32'h0);
        csr_op("rw_mip", A_MIP, F_RW, 32'hFFFF_FFFF, 5'd0, 32'h0);
        csr_peek("mip_ro", A_MIP, 32'h0);

        // Counters
        csr_op("rw_mcycleh", A_MCYCLEH, F_RW, 32'h5, 5'd0, 32'h0);
        csr_peek("mcycleh_val", A_MCYCLEH, 32'h5);
        csr_peek("minstreth_pre", A_MINSTRETH, 32'h0);
        idle();
        valid_MW = 1; csr_reg_wrMW = 1; csr_addr_MW = A_MINSTRET;
        InstF_MW_funct3 = F_RW; rs1_data_MW = 32'hFFFF_FFFF;
        tick();
        idle();
        csr_peek("minstret_wr", A_MINSTRET, 32'hFFFF_FFFF);
        valid_MW = 1;
        tick();
        idle();
        csr_peek("minstret_wrap", A_MINSTRET, 32'h0);
        csr_peek("minstreth_carry", A_MINSTRETH, 32'h1);

        // Reset while in handler (MIE=1, MTIE=1 at this point)
        irq_timer = 1;
        tick();
        valid_MW = 1;
        tick();
        idle();
        irq_timer = 0;
        check("pre_rst_handler", {31'b0, in_handler}, 32'h1);
        rst = 1;
        tick();
        rst = 0;
        check("rst_handler_exit", {31'b0, in_handler}, 32'h0);
        check("rst_epc_pc2", epc_pc, 32'h0);
        csr_peek("rst_mcause", A_MCAUSE, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0x%08h, expected 0x%08h", 32'h1, 32'h0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
